// File: rtl/state_gen_pkg.sv
// -----------------------------------------------------------------------------
// state_gen_pkg
// Shared definitions for the state_gen Horner sequencer:
//   - default sizing of the polynomial (NCOEF), fixed-point format (Q) and the
//     multiply-add latency (MULT_LAT)
//   - the accumulator clamp value and the operand value the multiply-add
//     treats specially on its b input
//   - the sequencer FSM state encoding
// -----------------------------------------------------------------------------
package state_gen_pkg;

    localparam int NCOEF_DEF    = 8;
    localparam int Q_DEF        = 15;
    localparam int MULT_LAT_DEF = 1;

    // Largest accumulator value ever fed back to the multiply-add b input.
    localparam logic [15:0] CLAMP_MAX       = 16'hFFFE;
    // b value on which the multiply-add substitutes a fixed constant.
    localparam logic [15:0] MULT_SENTINEL_B = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/state_gen_coef_bank.sv
// -----------------------------------------------------------------------------
// state_gen_coef_bank
// NCOEF x 16-bit coefficient register file.
//   clk, rst_n    clock, asynchronous active-low reset (bank clears to 0)
//   i_we          write strobe (already gated by the sequencer FSM)
//   i_waddr       write index
//   i_wdata       write data
//   i_ra_idx      read port A index   -> o_ra_data (combinational)
//   i_rb_idx      read port B index   -> o_rb_data (combinational)
// A read of the index being written in the same cycle returns the new data,
// so a write and an accept in the same cycle see the written value.
// -----------------------------------------------------------------------------
module state_gen_coef_bank
    import state_gen_pkg::*;
#(
    parameter int NCOEF = NCOEF_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [$clog2(NCOEF)-1:0]   i_waddr,
    input  logic [15:0]                i_wdata,
    input  logic [$clog2(NCOEF)-1:0]   i_ra_idx,
    output logic [15:0]                o_ra_data,
    input  logic [$clog2(NCOEF)-1:0]   i_rb_idx,
    output logic [15:0]                o_rb_data
);

    localparam int AW = $clog2(NCOEF);

    logic [15:0] r_coef [NCOEF];

    // NOTE: this small register file is reset explicitly because the design
    // must start from a known all-zero bank; large RAMs would normally not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                if (i_we && (i_waddr == AW'(i))) begin
                    r_coef[i] <= i_wdata;
                end
            end
        end
    end

    // Mux-based read keeps out-of-range indices (NCOEF not a power of two)
    // well defined, and forwards a same-cycle write.
    function automatic logic [15:0] read_port(input logic [AW-1:0] idx);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < NCOEF; i++) begin
            if (idx == AW'(i)) begin
                v = r_coef[i];
            end
        end
        if (i_we && (idx == i_waddr)) begin
            v = i_wdata;
        end
        return v;
    endfunction

    assign o_ra_data = read_port(i_ra_idx);
    assign o_rb_data = read_port(i_rb_idx);

endmodule

// File: rtl/state_gen_horner_seq.sv
// -----------------------------------------------------------------------------
// state_gen_horner_seq
// Evaluates an NCOEF-term unsigned Q1.15 polynomial in x by Horner's rule,
// one step per pass through an external registered multiply-add
// (p = a*b + c, MULT_LAT cycles), and hands the result to the state
// generator under a valid/ready handshake.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready high only in IDLE
//   x_in                   evaluation point (Q1.15)
//   cfg_we/addr/wdata      coefficient write port, honoured only in IDLE
//   mult_a/b/c, mult_p     multiply-add operands and result
//   y_out/out_valid        result, held until out_ready
//   out_ready              consumer accept
//   busy                   high in any state except IDLE
//   sat_flag               sticky per evaluation: some step clamped
// -----------------------------------------------------------------------------
module state_gen_horner_seq
    import state_gen_pkg::*;
#(
    parameter int NCOEF    = NCOEF_DEF,
    parameter int Q        = Q_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                x_in,
    input  logic                       cfg_we,
    input  logic [$clog2(NCOEF)-1:0]   cfg_addr,
    input  logic [15:0]                cfg_wdata,
    output logic [15:0]                mult_a,
    output logic [15:0]                mult_b,
    output logic [31:0]                mult_c,
    input  logic [32:0]                mult_p,
    output logic [15:0]                y_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       sat_flag
);

    localparam int KW = $clog2(NCOEF);
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    localparam logic [KW-1:0] K_TOP     = KW'(NCOEF - 1);
    localparam logic [KW-1:0] K_START   = KW'(NCOEF - 2);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MULT_LAT - 1);

    state_t        r_state;
    state_t        w_state_next;

    logic [15:0]   r_x;
    logic [15:0]   r_acc;
    logic [KW-1:0] r_k;
    logic [CW-1:0] r_wait_cnt;
    logic [15:0]   r_mult_a;
    logic [15:0]   r_mult_b;
    logic [31:0]   r_mult_c;
    logic [15:0]   r_y;
    logic          r_out_valid;
    logic          r_sat;

    logic          w_accept;
    logic          w_bank_we;
    logic [KW-1:0] w_rb_idx;
    logic [15:0]   w_coef_top;
    logic [15:0]   w_coef_k;
    logic [31:0]   w_c_next;
    logic          w_wait_last;
    logic [32:0]   w_t;
    logic          w_step_sat;
    logic [15:0]   w_step_acc;
    logic          w_top_sat;
    logic [15:0]   w_top_acc;

    // ------------------------------------------------------------------
    // Coefficient bank: writes only land while IDLE.
    // Port A always reads the leading coefficient (initial accumulator);
    // port B reads the coefficient added by the next step to be issued.
    // ------------------------------------------------------------------
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_bank_we = cfg_we && (r_state == IDLE);
    assign w_rb_idx  = (r_state == IDLE) ? K_START : (r_k - KW'(1));

    state_gen_coef_bank #(
        .NCOEF (NCOEF)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_bank_we),
        .i_waddr   (cfg_addr),
        .i_wdata   (cfg_wdata),
        .i_ra_idx  (K_TOP),
        .o_ra_data (w_coef_top),
        .i_rb_idx  (w_rb_idx),
        .o_rb_data (w_coef_k)
    );

    // c operand: coefficient aligned to the Q-scaled product.
    assign w_c_next = 32'({w_coef_k, {Q{1'b0}}});

    // Step result with clamp. The accumulator feeds mult_b on the next
    // step, so it must never reach the multiply-add sentinel value.
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);
    assign w_t         = mult_p >> Q;
    assign w_step_sat  = (w_t > 33'(CLAMP_MAX));
    assign w_step_acc  = w_step_sat ? CLAMP_MAX : w_t[15:0];

    // The leading coefficient goes straight to mult_b on the first step,
    // so it is clamped the same way.
    assign w_top_sat = (w_coef_top == MULT_SENTINEL_B);
    assign w_top_acc = w_top_sat ? CLAMP_MAX : w_coef_top;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred
    // latches on any path through the case.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_wait_last) w_state_next = (r_k == '0) ? DONE : ISSUE;
            DONE:    if (r_out_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Operands for a step are loaded on the edge entering ISSUE
    // so they are on the pins during ISSUE and held through WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_wait_cnt  <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_mult_c    <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x      <= x_in;
                        r_acc    <= w_top_acc;
                        r_sat    <= w_top_sat;
                        r_k      <= K_START;
                        r_mult_a <= x_in;
                        r_mult_b <= w_top_acc;
                        r_mult_c <= w_c_next;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                end
                WAIT: begin
                    if (!w_wait_last) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end else begin
                        r_acc <= w_step_acc;
                        if (w_step_sat) begin
                            r_sat <= 1'b1;
                        end
                        if (r_k != '0) begin
                            r_k      <= r_k - KW'(1);
                            r_mult_a <= r_x;
                            r_mult_b <= w_step_acc;
                            r_mult_c <= w_c_next;
                        end
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds
                    // until the consumer takes it.
                    if (!r_out_valid) begin
                        r_y         <= r_acc;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign mult_c    = r_mult_c;
    assign y_out     = r_y;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat;

endmodule

// File: doc/state_gen_horner_seq.md
Name: state_gen_horner_seq

Overview:
- Upstream sequencer for the state_gen multiply-add stage (p = a*b + c, registered, 1-cycle latency, 33-bit p).
- Evaluates an NCOEF-term unsigned fixed-point polynomial in x by Horner's rule.
- Drives one a/b/c operand set per step into the multiply-add and takes p back.
- Returns the 16-bit state value to the state generator under a valid/ready handshake.

Parameters:
- NCOEF, 8, number of polynomial coefficients (2..16).
- Q, 15, fractional bits of all 16-bit operands (unsigned Q1.15).
- MULT_LAT, 1, cycles from driving a/b/c to p valid.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x_in offered.
- in_ready  out  1  high only in IDLE.
- x_in  in  16  evaluation point, Q1.15.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  $clog2(NCOEF)  coefficient index k.
- cfg_wdata  in  16  coefficient value coef[k].
- mult_a  out  16  to multiply-add a.
- mult_b  out  16  to multiply-add b.
- mult_c  out  32  to multiply-add c.
- mult_p  in  33  from multiply-add p.
- y_out  out  16  result.
- out_valid  out  1  y_out valid, held until accepted.
- out_ready  in  1  consumer accept.
- busy  out  1  high in any state except IDLE.
- sat_flag  out  1  sticky per evaluation: any step clamped.

Behaviour:
- Reset (async on rst_n low, released synchronously):
  - FSM to IDLE; coefficient bank cleared to 0.
  - mult_a/mult_b/mult_c = 0; y_out = 0; out_valid = 0; sat_flag = 0; busy = 0; in_ready = 1.
- Reset mid-evaluation aborts it; no out_valid follows.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_valid & in_ready accepts the input: latch x = x_in, acc = coef[NCOEF-1], k = NCOEF-2, clear sat_flag, go to ISSUE.
  - cfg_we writes coef[cfg_addr] = cfg_wdata.
  - A write and an accept in the same cycle: the write lands first, so the evaluation uses the new value.
- cfg_we outside IDLE is ignored; the bank is unchanged.
- ISSUE (1 cycle): drive mult_a = x, mult_b = acc, mult_c = {coef[k], Q zeros} zero-extended to 32; go to WAIT.
- WAIT (MULT_LAT cycles, counter):
  - Operands are held stable throughout.
  - On the last WAIT cycle sample mult_p, t = mult_p >> Q.
  - If t > 16'hFFFE: acc = 16'hFFFE and sat_flag = 1; otherwise acc = t[15:0].
  - If k == 0 go to DONE, else decrement k and go to ISSUE.
- Clamp at 16'hFFFE is mandatory: the multiply-add substitutes a fixed constant when b == 16'hFFFF, so mult_b must never carry 16'hFFFF.
- Width check: max p = 0xFFFF*0xFFFE + (0xFFFF<<15) < 2^33, so no overflow.
- DONE:
  - y_out = acc, out_valid = 1; y_out and sat_flag held stable.
  - out_ready high: out_valid drops next cycle, go to IDLE.
- Latency: accept to out_valid = (NCOEF-1)*(1+MULT_LAT) + 1 cycles; 15 at the defaults.
- No new input is accepted before the output handshake completes (in_ready = 0).
- Operand outputs keep their last values in IDLE/DONE; the multiply-add result is ignored there.

Decomposition:
- Package state_gen_pkg:
  - default NCOEF, Q, MULT_LAT;
  - CLAMP_MAX = 16'hFFFE;
  - MULT_SENTINEL_B = 16'hFFFF;
  - state enum {IDLE, ISSUE, WAIT, DONE}.
- Sub-module state_gen_coef_bank: NCOEF x 16 register file with async reset, synchronous write port gated by a write-enable from the FSM, combinational read by index. The FSM, counters and clamp stay in the top.
- Bench connects the real multiply-add stage to mult_a/b/c/p.

Test Plan:
- coef[0] = 0x1234, others 0; x_in = 0x4000 -> y_out = 0x1234 after 15 cycles, sat_flag = 0.
- All coef = 0x1000, x_in = 0x8000 (1.0) -> y_out = 0x8000, sat_flag = 0.
- All coef = 0xFFFF, x_in = 0xFFFF -> every mult_b <= 0xFFFE, y_out = 0xFFFE, sat_flag = 1.
- Backpressure: hold out_ready low 5 cycles after out_valid -> y_out stable, in_ready = 0; a second in_valid is not accepted until after the handshake.
- cfg_we to coef[7] with 0x5555 while busy -> bank unchanged; the next evaluation uses the old value.
- rst_n low in WAIT of step 3 -> all outputs at reset values immediately; after release in_ready = 1; the next evaluation is correct.
